acc_alu: RTL and testbench

ACC_ALU -- requirements
Module: acc_alu

---
 rtl/acc_alu.sv | 199 +++++++++++++++++++
 tb/tb_acc_alu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_alu.sv
// Accumulator ALU: a small register bank with single-cycle ALU ops and an
// iterative shift-add multiplier, gated by a simple IDLE/MUL/OFF power FSM.
module acc_alu #(
  parameter int N  = 8,
  parameter int RW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          on,
  input  logic          off,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    op,
  input  logic [RW-1:0] sel,
  input  logic [N-1:0]  in,
  output logic [N-1:0]  out,
  output logic          out_valid,
  output logic          zero,
  output logic          carry,
  output logic          ovf,
  output logic          pwr,
  output logic [1:0]    dbg_state
);
  localparam int R  = 1 << RW;
  localparam int CW = $clog2(N);

  localparam logic [3:0] OP_LOAD = 4'd1, OP_NOT = 4'd2, OP_XOR = 4'd3,
                         OP_OR   = 4'd4, OP_AND = 4'd5, OP_SUB = 4'd6,
                         OP_ADD  = 4'd7, OP_MUL = 4'd8, OP_CLR = 4'd9,
                         OP_SHL  = 4'd10, OP_SHR = 4'd11;

  // Handshake: an op is taken on a rising edge where in_valid & in_ready and
  // no power-off request is pending; in_ready depends only on the state.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_OFF = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      regs_q [R];
  logic [N-1:0]      regs_d [R];
  logic [N-1:0]      out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
  logic [2*N-1:0]    mcand_q, mcand_d, prod_q, prod_d, prod_nx;
  logic [N-1:0]      mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     msel_q, msel_d;

  logic              off_req, accept, mul_last;
  logic [N-1:0]      a;
  logic [N:0]        sum, diff;
  logic [N-1:0]      alu_res;
  logic              alu_c, alu_o, alu_wr;

  assign off_req  = off & ~on;
  assign accept   = (state_q == S_IDLE) & in_valid & ~off_req;
  assign mul_last = (cnt_q == CW'(N - 1));
  assign a        = regs_q[sel];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (off_req) state_d = S_OFF;
              else if (accept && op == OP_MUL) state_d = S_MUL;
      S_MUL:  if (off_req) state_d = S_OFF;
              else if (mul_last) state_d = S_IDLE;
      S_OFF:  if (on) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    pwr       = (state_q != S_OFF);
    dbg_state = state_q;
  end

  always_comb begin
    sum     = {1'b0, a} + {1'b0, in};
    diff    = {1'b0, a} - {1'b0, in};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    alu_wr  = 1'b1;
    case (op)
      OP_LOAD: alu_res = in;
      OP_NOT:  alu_res = ~a;
      OP_XOR:  alu_res = a ^ in;
      OP_OR:   alu_res = a | in;
      OP_AND:  alu_res = a & in;
      OP_SUB: begin
        alu_res = diff[N-1:0];
        alu_c   = diff[N];
        alu_o   = (a[N-1] ^ in[N-1]) & (diff[N-1] ^ a[N-1]);
      end
      OP_ADD: begin
        alu_res = sum[N-1:0];
        alu_c   = sum[N];
        alu_o   = ~(a[N-1] ^ in[N-1]) & (sum[N-1] ^ a[N-1]);
      end
      OP_CLR:  alu_res = '0;
      OP_SHL: begin
        alu_res = {a[N-2:0], 1'b0};
        alu_c   = a[N-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a[N-1:1]};
        alu_c   = a[0];
      end
      default: alu_wr = 1'b0;
    endcase
  end

  always_comb begin
    regs_d      = regs_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    msel_d      = msel_q;
    prod_nx     = prod_q + (mplier_q[0] ? mcand_q : '0);
    if (accept) begin
      if (op == OP_MUL) begin
        mcand_d  = {{N{1'b0}}, a};
        mplier_d = in;
        prod_d   = '0;
        cnt_d    = '0;
        msel_d   = sel;
      end else if (alu_wr) begin
        regs_d[sel] = alu_res;
        out_d       = alu_res;
        zero_d      = (alu_res == '0);
        carry_d     = alu_c;
        ovf_d       = alu_o;
        out_valid_d = 1'b1;
      end
    end
    // One shift-add step per edge; an off request abandons the product.
    if (state_q == S_MUL && !off_req) begin
      prod_d   = prod_nx;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (mul_last) begin
        regs_d[msel_q] = prod_nx[N-1:0];
        out_d          = prod_nx[N-1:0];
        zero_d         = (prod_nx[N-1:0] == '0);
        carry_d        = |prod_nx[2*N-1:N];
        ovf_d          = |prod_nx[2*N-1:N];
        out_valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < R; i++) regs_q[i] <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      msel_q      <= '0;
    end else begin
      regs_q      <= regs_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      msel_q      <= msel_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_acc_alu.sv
// Bench for acc_alu: directed scenarios plus random ops, with results checked
// by a queue-based scoreboard against an arithmetic reference model.
module tb_acc_alu;
  localparam int N  = 8;
  localparam int RW = 2;
  localparam int R  = 4;
  localparam int M  = 256;
  localparam int H  = 128;
  localparam int W  = 16 + N + 3;

  logic          clk = 1'b0;
  logic          rst, on, off, in_valid, in_ready;
  logic [3:0]    op;
  logic [RW-1:0] sel;
  logic [N-1:0]  in_b, out;
  logic          out_valid, zero, carry, ovf, pwr;
  logic [1:0]    dbg_state;

  acc_alu #(.N(N), .RW(RW)) dut (
    .clk(clk), .rst(rst), .on(on), .off(off), .in_valid(in_valid),
    .in_ready(in_ready), .op(op), .sel(sel), .in(in_b), .out(out),
    .out_valid(out_valid), .zero(zero), .carry(carry), .ovf(ovf),
    .pwr(pwr), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // entry = {expected cycle of out_valid, out, zero, carry, ovf}
  logic [W-1:0] exp_q[$];

  // reference model state
  int m_reg[R];
  int m_out;
  bit m_z, m_c, m_o;
  bit m_on;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic expect_out(input string name, input int o, input bit z, input bit c, input bit v);
    check(name, {out, zero, carry, ovf}, {o[N-1:0], z, c, v});
  endtask

  function automatic void model_op(input int o, input int a, input int b,
                                   output int r, output bit c, output bit v, output bit wr);
    int sa, sb, t;
    sa = (a >= H) ? a - M : a;
    sb = (b >= H) ? b - M : b;
    wr = 1'b1; c = 1'b0; v = 1'b0; r = 0;
    case (o)
      1: r = b;
      2: r = M - 1 - a;
      3: r = a ^ b;
      4: r = a | b;
      5: r = a & b;
      6: begin t = a - b; r = (t + M) % M; c = (a < b); v = (sa - sb >= H) || (sa - sb < -H); end
      7: begin t = a + b; r = t % M; c = (t >= M); v = (sa + sb >= H) || (sa + sb < -H); end
      8: begin t = a * b; r = t % M; c = (t >= M); v = c; end
      9: r = 0;
      10: begin r = (a * 2) % M; c = (a >= H); end
      11: begin r = a / 2; c = (a % 2) == 1; end
      default: wr = 1'b0;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge; the op is presented to the next rising edge.
  // With finish_mul=0 a MULT is left running and is not expected to complete.
  task automatic issue(input int o, input int s, input int b, input bit finish_mul);
    int r, a, lat, cnt;
    bit c, v, wr;
    logic [W-1:0] item;
    a = m_reg[s];
    op = 4'(o); sel = RW'(s); in_b = N'(b); in_valid = 1'b1;
    if (m_on) begin
      model_op(o, a, b, r, c, v, wr);
      if (wr && (o != 8 || finish_mul)) begin
        lat = (o == 8) ? N : 0;
        m_reg[s] = r; m_out = r; m_z = (r == 0); m_c = c; m_o = v;
        item = {16'(cyc + 1 + lat), N'(r), (r == 0), c, v};
        exp_q.push_back(item);
      end
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; op = 4'd0;
    if (m_on && o == 8 && finish_mul) begin
      cnt = 0;
      while (!in_ready && cnt < 4 * N) begin
        cnt++;
        @(negedge clk);
      end
      check("mul_busy_cycles", cnt, N);
    end
  endtask

  task automatic pulse(input bit p_on, input bit p_off);
    on = p_on; off = p_off;
    @(posedge clk);
    @(negedge clk);
    on = 1'b0; off = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    while (exp_q.size() > 0 && int'(exp_q[0][W-1:N+3]) < cyc) begin
      e = exp_q.pop_front();
      chk_cnt++;
      $display("FAIL sb_missing: no out_valid at cycle %0d, expected out=0x%0h", int'(e[W-1:N+3]), e[N+2:3]);
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL sb_unexpected: out_valid at cycle %0d with out=0x%0h, expected none", cyc, out);
      end else begin
        e = exp_q.pop_front();
        check("sb_result{cycle,out,z,c,v}", {cyc[15:0], out, zero, carry, ovf}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; on = 1'b0; off = 1'b0; in_valid = 1'b0;
    op = 4'd0; sel = '0; in_b = '0;
    m_on = 1'b1; m_out = 0; m_z = 0; m_c = 0; m_o = 0;
    for (int i = 0; i < R; i++) m_reg[i] = 0;
    #1;
    check("reset_state", {out, out_valid, zero, carry, ovf, pwr, in_ready},
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    rst = 1'b0;

    // basic load / add, register isolation
    issue(1, 0, 'h10, 1);
    issue(7, 0, 'h06, 1);
    expect_out("add_0x16", 'h16, 0, 0, 0);
    issue(1, 1, 'h00, 1);
    issue(7, 1, 'h00, 1);
    expect_out("reg1_zero", 'h00, 1, 0, 0);

    // overflow and carry corners
    issue(1, 0, 'h7F, 1);
    issue(7, 0, 'h01, 1);
    expect_out("add_ovf", 'h80, 0, 0, 1);
    issue(7, 0, 'h80, 1);
    expect_out("add_wrap", 'h00, 1, 1, 1);
    issue(6, 0, 'h01, 1);
    expect_out("sub_borrow", 'hFF, 0, 1, 0);

    // multiply
    issue(1, 2, 'h06, 1);
    issue(8, 2, 'h04, 1);
    expect_out("mul_0x18", 'h18, 0, 0, 0);
    issue(1, 2, 'h20, 1);
    issue(8, 2, 'h10, 1);
    expect_out("mul_overflow", 'h00, 1, 1, 1);

    // shifts and NOPs
    issue(1, 3, 'h81, 1);
    issue(10, 3, 0, 1);
    expect_out("shl", 'h02, 0, 1, 0);
    issue(1, 3, 'h01, 1);
    issue(11, 3, 0, 1);
    expect_out("shr", 'h00, 1, 1, 0);
    for (int o = 12; o < 16; o++) issue(o, o - 12, 'hA5, 1);
    issue(0, 0, 'h5A, 1);
    expect_out("nop_flags_held", m_out, m_z, m_c, m_o);

    // power off in IDLE
    pulse(0, 1);
    m_on = 1'b0;
    check("off_pwr_ready", {pwr, in_ready}, 2'b00);
    issue(1, 0, 'hFF, 1);
    expect_out("off_load_ignored", m_out, m_z, m_c, m_o);
    pulse(1, 0);
    m_on = 1'b1;
    check("on_pwr_ready", {pwr, in_ready}, 2'b11);
    pulse(0, 1);
    check("off_again", pwr, 1'b0);
    pulse(1, 1);
    check("on_off_together", {pwr, in_ready}, 2'b11);
    issue(7, 0, 'h00, 1);

    // off on the third MUL cycle aborts without writing
    issue(1, 1, 'h33, 1);
    issue(8, 1, 'h05, 0);
    @(negedge clk);
    @(negedge clk);
    pulse(0, 1);
    m_on = 1'b0;
    check("mul_abort_off", {pwr, in_ready}, 2'b00);
    repeat (N) @(negedge clk);
    pulse(1, 0);
    m_on = 1'b1;
    issue(7, 1, 'h00, 1);
    expect_out("mul_abort_reg_kept", 'h33, 0, 0, 0);

    // asynchronous reset in the middle of a MULT
    issue(1, 2, 'h55, 1);
    issue(8, 2, 'h03, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_mul", {out, out_valid, zero, carry, ovf, pwr, in_ready},
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    for (int i = 0; i < R; i++) m_reg[i] = 0;
    m_out = 0; m_z = 0; m_c = 0; m_o = 0;
    exp_q.delete();
    #1 rst = 1'b0;
    issue(7, 0, 'h09, 1);
    expect_out("first_op_after_rst", 'h09, 0, 0, 0);
    issue(7, 2, 'h00, 1);
    expect_out("reg2_cleared", 'h00, 1, 0, 0);

    // random operations
    for (int k = 0; k < 60; k++)
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, R - 1)),
            int'($urandom_range(0, M - 1)), 1);
    expect_out("random_final_state", m_out, m_z, m_c, m_o);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
